mvau_weight_loader: RTL and testbench

Runtime loader that fills the MVAU per-PE weight memories from an AXI-stream of weight words, replacing the `$readmemh` initialisation path when weights must change after configuration. It sits between the weight input stream and the write ports of the PE weight memories. Each accepted `SIMD*TW`-bit word is steered to one PE memory and one address. A done pulse tells the MVAU control that the memories are valid.

---
 rtl/mvau_weight_loader_pkg.sv | 7 +
 rtl/mvau_weight_mem_rw.sv | 21 ++
 rtl/mvau_weight_loader.sv | 64 ++++++
 tb/tb_mvau_weight_loader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mvau_weight_loader_pkg.sv
// mvau_weight_loader_pkg: shared state type and counter-width helper for the weight loader
package mvau_weight_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  function automatic int cnt_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mvau_weight_mem_rw.sv
// mvau_weight_mem_rw: PE weight memory with a synchronous write port and registered read port
module mvau_weight_mem_rw #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    we,
  input  logic [WMEM_ADDR_BW-1:0] waddr,
  input  logic [SIMD*TW-1:0]      wdata,
  input  logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic [SIMD*TW-1:0]      wmem_out
);
  logic [SIMD*TW-1:0] mem [2**WMEM_ADDR_BW];
  logic [SIMD*TW-1:0] out_q;
  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
    out_q <= mem[wmem_addr];
  end
  assign wmem_out = out_q;
endmodule

// File: rtl/mvau_weight_loader.sv
// mvau_weight_loader: steers a weight stream into PE memories, address-major / PE-minor
module mvau_weight_loader #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int PE           = 2,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [SIMD*TW-1:0]      in_wgt_tdata,
  input  logic                    in_wgt_tvalid,
  output logic                    in_wgt_tready,
  output logic [PE-1:0]           wmem_we,
  output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
  output logic [SIMD*TW-1:0]      wmem_wdata,
  output logic                    busy,
  output logic                    done
);
  import mvau_weight_loader_pkg::*;
  localparam int PCW = cnt_bw(PE);
  state_e state_q, state_d;
  logic [PCW-1:0] pe_cnt_q, pe_cnt_d;
  logic [WMEM_ADDR_BW-1:0] addr_cnt_q, addr_cnt_d, waddr_q, waddr_d;
  logic [PE-1:0] we_q, we_d;
  logic [SIMD*TW-1:0] wdata_q, wdata_d;
  logic hs, pe_wrap, last;
  // addr_cnt parks at WMEM_DEPTH-1 on the last word instead of wrapping
  always_comb begin
    hs = state_q == LOAD && in_wgt_tvalid;
    pe_wrap = pe_cnt_q == PCW'(PE - 1);
    last = hs && pe_wrap && addr_cnt_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1);
    state_d = state_q == IDLE ? (start ? LOAD : IDLE) : state_q == LOAD ? (last ? DONE : LOAD) : IDLE;
    pe_cnt_d = state_q == IDLE ? '0 : hs ? (pe_wrap ? '0 : pe_cnt_q + PCW'(1)) : pe_cnt_q;
    addr_cnt_d = state_q == IDLE ? '0 : (hs && pe_wrap && !last) ? addr_cnt_q + WMEM_ADDR_BW'(1) : addr_cnt_q;
    we_d = hs ? PE'(1) << pe_cnt_q : '0;
    waddr_d = hs ? addr_cnt_q : waddr_q;
    wdata_d = hs ? in_wgt_tdata : wdata_q;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      pe_cnt_q <= '0;
      addr_cnt_q <= '0;
      we_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pe_cnt_q <= pe_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign in_wgt_tready = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign wmem_we = we_q;
  assign wmem_waddr = waddr_q;
  assign wmem_wdata = wdata_q;
endmodule

// File: tb/tb_mvau_weight_loader.sv
// tb_mvau_weight_loader: directed/randomized checks of the loader against a word-index reference model
module tb_mvau_weight_loader;
  localparam int P = 2;
  localparam int D = 4;
  localparam int N = P * D;
  logic aclk = 1'b0, areset = 1'b1;
  logic start = 1'b0, tvalid = 1'b0, tready, busy, done;
  logic [1:0] tdata = '0, wdata;
  logic [1:0] we;
  logic [3:0] waddr, rd_addr = '0;
  logic [1:0] rd0, rd1;
  logic start1 = 1'b0, tvalid1 = 1'b0, tready1, busy1, done1;
  logic [1:0] tdata1 = '0, wdata1;
  logic [0:0] we1;
  logic [3:0] waddr1;
  int tests = 0, fails = 0;
  int m_ph = 0, m_k = 0;
  logic [1:0] e_we = '0, e_data = '0;
  logic [3:0] e_addr = '0;
  logic [1:0] mm [P][D];

  always #5 aclk = ~aclk;

  mvau_weight_loader #(.SIMD(2), .TW(1), .PE(P), .WMEM_DEPTH(D), .WMEM_ADDR_BW(4)) dut (
    .aclk(aclk), .areset(areset), .start(start), .in_wgt_tdata(tdata), .in_wgt_tvalid(tvalid),
    .in_wgt_tready(tready), .wmem_we(we), .wmem_waddr(waddr), .wmem_wdata(wdata), .busy(busy), .done(done));
  mvau_weight_loader #(.SIMD(2), .TW(1), .PE(1), .WMEM_DEPTH(3), .WMEM_ADDR_BW(4)) dut1 (
    .aclk(aclk), .areset(areset), .start(start1), .in_wgt_tdata(tdata1), .in_wgt_tvalid(tvalid1),
    .in_wgt_tready(tready1), .wmem_we(we1), .wmem_waddr(waddr1), .wmem_wdata(wdata1), .busy(busy1), .done(done1));
  mvau_weight_mem_rw #(.SIMD(2), .TW(1), .WMEM_ADDR_BW(4)) mem0 (
    .aclk(aclk), .we(we[0]), .waddr(waddr), .wdata(wdata), .wmem_addr(rd_addr), .wmem_out(rd0));
  mvau_weight_mem_rw #(.SIMD(2), .TW(1), .WMEM_ADDR_BW(4)) mem1 (
    .aclk(aclk), .we(we[1]), .waddr(waddr), .wdata(wdata), .wmem_addr(rd_addr), .wmem_out(rd1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_tready"}, 32'(tready), 32'(m_ph == 1));
    chk({tag, "_busy"}, 32'(busy), 32'(m_ph != 0));
    chk({tag, "_done"}, 32'(done), 32'(m_ph == 2));
    chk({tag, "_we"}, 32'(we), 32'(e_we));
    chk({tag, "_waddr"}, 32'(waddr), 32'(e_addr));
    chk({tag, "_wdata"}, 32'(wdata), 32'(e_data));
  endtask

  // one clock of stimulus; word k of a load lands at pe k%P, addr k/P one cycle later
  task automatic cyc(input string tag, input logic v, input logic s, input logic [1:0] d);
    logic hs;
    tvalid = v;
    start = s;
    tdata = d;
    hs = (m_ph == 1) && v;
    @(posedge aclk);
    #1;
    e_we = '0;
    if (hs) begin
      e_we = (m_k % P == 0) ? 2'b01 : 2'b10;
      e_addr = 4'(m_k / P);
      e_data = d;
      mm[m_k % P][m_k / P] = d;
      m_k++;
    end
    if (m_ph == 0) begin
      if (s) begin m_ph = 1; m_k = 0; end
    end else if (m_ph == 1) begin
      if (m_k == N) m_ph = 2;
    end else m_ph = 0;
    chk_outs(tag);
  endtask

  task automatic readback(input string tag);
    tvalid = 1'b0;
    for (int a = 0; a < D; a++) begin
      rd_addr = 4'(a);
      @(posedge aclk);
      #1;
      chk({tag, "_mem0"}, 32'(rd0), 32'(mm[0][a]));
      chk({tag, "_mem1"}, 32'(rd1), 32'(mm[1][a]));
    end
  endtask

  task automatic mid_reset(input string tag);
    #2 areset = 1'b1;
    #1;
    m_ph = 0; m_k = 0; e_we = '0; e_addr = '0; e_data = '0;
    chk_outs(tag);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    #2;
    chk_outs("por");
    @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) cyc("idle_valid", 1'b1, 1'b0, 2'($urandom));
    cyc("start", 1'b0, 1'b1, 2'b00);
    for (int k = 0; k < N; k++) cyc("full", 1'b1, 1'b0, 2'(k % 4));
    cyc("done_valid_ignored", 1'b1, 1'b0, 2'($urandom));
    cyc("back_idle", 1'b0, 1'b0, 2'b00);
    readback("full_rb");
    cyc("bp_start", 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 40 && m_ph != 2; i++) cyc("bp", i % 3 == 0, i == 4, 2'($urandom));
    cyc("bp_tail", 1'b0, 1'b0, 2'b00);
    readback("bp_rb");
    cyc("abort_start", 1'b0, 1'b1, 2'b00);
    for (int k = 0; k < 5; k++) cyc("abort", 1'b1, 1'b0, 2'($urandom));
    mid_reset("async_rst");
    cyc("post_rst_idle", 1'b1, 1'b0, 2'($urandom));
    cyc("reload_start", 1'b0, 1'b1, 2'b00);
    for (int k = 0; k < N; k++) cyc("reload", 1'b1, 1'b0, 2'($urandom));
    cyc("reload_tail", 1'b0, 1'b0, 2'b00);
    cyc("reload_idle", 1'b0, 1'b0, 2'b00);
    readback("reload_rb");
    start1 = 1'b1;
    @(posedge aclk);
    #1;
    start1 = 1'b0;
    chk("pe1_tready", 32'(tready1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      logic [1:0] d;
      d = 2'($urandom);
      tvalid1 = 1'b1;
      tdata1 = d;
      @(posedge aclk);
      #1;
      chk("pe1_we", 32'(we1), 32'd1);
      chk("pe1_waddr", 32'(waddr1), 32'(i));
      chk("pe1_wdata", 32'(wdata1), 32'(d));
      chk("pe1_done", 32'(done1), 32'(i == 2));
    end
    tvalid1 = 1'b0;
    @(posedge aclk);
    #1;
    chk("pe1_busy_end", 32'(busy1), 32'd0);
    chk("pe1_we_end", 32'(we1), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
